// File: rtl/pwm_output_stage.sv
// Drives 16 user outputs: each is forced low, forced high, or follows one shared 8-bit PWM.
// The duty value is shadowed and takes effect only at the period wrap, so the waveform never glitches.
module pwm_output_stage #(
  parameter int PRESCALE = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] prescale_cnt;
  logic [7:0]    pwm_cnt;
  logic [7:0]    duty_shadow;
  logic [15:0]   out_q;
  logic [15:0]   en_out;
  logic [15:0]   en_pwm;
  logic          step;
  logic          wrap;
  logic          pwm_raw;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  assign step = (prescale_cnt == PS_LAST);
  assign wrap = step && (pwm_cnt == 8'hFF);

  // 0xFF is treated as a true 100% so there is no single low step at the wrap.
  assign pwm_raw = (duty_shadow == 8'hFF) || (pwm_cnt < duty_shadow);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescale_cnt <= '0;
      pwm_cnt      <= '0;
    end else begin
      if (step) begin
        prescale_cnt <= '0;
        pwm_cnt      <= pwm_cnt + 8'd1;
      end else begin
        prescale_cnt <= prescale_cnt + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty_shadow <= '0;
    end else if (wrap) begin
      duty_shadow <= pwm_duty_cycle;
    end
  end

  // Enables are deliberately not shadowed: mode changes show up on the very next edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= en_out & (~en_pwm | {16{pwm_raw}});
    end
  end

  assign out          = out_q;
  assign period_start = (prescale_cnt == '0) && (pwm_cnt == 8'd0);

endmodule

// File: tb/tb_pwm_output_stage.sv
// Randomized and directed bench for pwm_output_stage; a time-based reference model
// predicts each cycle's outputs into a queue that an independent monitor drains.
module tb_pwm_output_stage;

  localparam int P      = 13;
  localparam int PERIOD = 256 * P;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  en_reg_out_7_0, en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0, en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        period_start;

  typedef struct packed {
    logic [15:0] out;
    logic        ps;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  int unsigned idx    = 0;
  logic [7:0]  duty_m = 8'h00;

  pwm_output_stage #(.PRESCALE(P)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .out             (out),
    .period_start    (period_start)
  );

  always #5 clk = ~clk;

  // Model: position within the period is elapsed cycles since reset modulo the period.
  task automatic modelStep();
    exp_t        e;
    int unsigned pos;
    logic [15:0] eo;
    logic [15:0] ep;
    bit          hi;
    eo = {en_reg_out_15_8, en_reg_out_7_0};
    ep = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    e  = '0;
    if (!rst_n) begin
      e.out  = 16'h0000;
      idx    = 0;
      duty_m = 8'h00;
    end else begin
      pos = idx % PERIOD;
      hi  = (duty_m == 8'hFF) || (pos < int'(duty_m) * P);
      for (int i = 0; i < 16; i++)
        e.out[i] = eo[i] && (!ep[i] || hi);
      if (pos == PERIOD - 1)
        duty_m = pwm_duty_cycle;
      idx = (idx + 1) % PERIOD;
    end
    e.ps = (idx == 0);
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic r, input logic [15:0] eo, input logic [15:0] ep,
                               input logic [7:0] d, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      rst_n           = r;
      en_reg_out_7_0  = eo[7:0];
      en_reg_out_15_8 = eo[15:8];
      en_reg_pwm_7_0  = ep[7:0];
      en_reg_pwm_15_8 = ep[15:8];
      pwm_duty_cycle  = d;
      modelStep();
    end
  endtask

  task automatic runToPwm(input logic [15:0] eo, input logic [15:0] ep,
                          input logic [7:0] d, input int target);
    int guard = 0;
    while (idx != target * P && guard < PERIOD + 1) begin
      applyStimulus(1'b1, eo, ep, d, 1);
      guard++;
    end
  endtask

  task automatic checkOutput(input exp_t e);
    n_cmp++;
    if (out !== e.out) begin
      n_fail++;
      $display("[TB] FAIL out @%0t: got %h expected %h", $time, out, e.out);
    end
    n_cmp++;
    if (period_start !== e.ps) begin
      n_fail++;
      $display("[TB] FAIL period_start @%0t: got %b expected %b", $time, period_start, e.ps);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin : watchdog
    #(90000 * 10);
    $display("[TB] FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "[TB] time limit expired");
  end

  initial begin : stimulus
    logic [15:0] reo, rep;
    logic [7:0]  rd;
    int          len;
    rst_n = 1'b0;
    {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8} = '1;
    pwm_duty_cycle = 8'hFF;

    $display("[TB] reset with all inputs high");
    applyStimulus(1'b0, 16'hFFFF, 16'hFFFF, 8'hFF, 5);
    applyStimulus(1'b1, 16'hFFFF, 16'hFFFF, 8'hFF, PERIOD + 40);
    applyStimulus(1'b1, 16'hFFFF, 16'h0000, 8'hFF, 10);

    $display("[TB] static enable");
    applyStimulus(1'b1, 16'h0001, 16'h0000, 8'h80, 5);
    applyStimulus(1'b1, 16'h0000, 16'h0000, 8'h80, 5);

    $display("[TB] 50 percent duty");
    applyStimulus(1'b1, 16'h8001, 16'h8001, 8'h80, 3 * PERIOD);

    $display("[TB] duty extremes");
    applyStimulus(1'b1, 16'h8001, 16'h8001, 8'h00, 3 * PERIOD);
    applyStimulus(1'b1, 16'h8001, 16'h8001, 8'hFF, 3 * PERIOD);

    $display("[TB] mid-period duty update");
    applyStimulus(1'b1, 16'h8001, 16'h8001, 8'h40, 2);
    runToPwm(16'h8001, 16'h8001, 8'h40, 0);
    runToPwm(16'h8001, 16'h8001, 8'h40, 50);
    applyStimulus(1'b1, 16'h8001, 16'h8001, 8'hC0, 2 * PERIOD + 20);

    $display("[TB] reset during high phase");
    runToPwm(16'h8001, 16'h8001, 8'hC0, 100);
    applyStimulus(1'b0, 16'h8001, 16'h8001, 8'hC0, 1);
    applyStimulus(1'b1, 16'h8001, 16'h8001, 8'hC0, PERIOD + 20);

    $display("[TB] randomized segments");
    for (int s = 0; s < 6; s++) begin
      reo = 16'($urandom);
      rep = 16'($urandom);
      rd  = 8'($urandom);
      len = $urandom_range(50, 1500);
      applyStimulus(($urandom_range(0, 9) != 0), reo, rep, rd, 1);
      applyStimulus(1'b1, reo, rep, rd, len);
    end
    for (int c = 0; c < 200; c++)
      applyStimulus(($urandom_range(0, 49) != 0), 16'($urandom), 16'($urandom), 8'($urandom), 1);

    @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
